tomasulo: RTL and testbench
===========================

TOMASULO -- requirements
Module: tomasulo

Interface
REQ-001 Parameter DATA_W, default 8, register/data width.
REQ-002 Parameter ADD_LAT, default 2, add/sub unit latency in cycles (>=1).
REQ-003 Parameter MUL_LAT, default 4, multiply unit latency in cycles (>=1).
REQ-004 clk1  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pc  input  4  instruction memory index for issue.
REQ-007 issue_en  input  1  request to issue imem[pc] this cycle.
REQ-008 imem_we, imem_addr[3:0], imem_wdata[15:0]  inputs  instruction memory write port.
REQ-009 stall  output  1  combinational; issue refused this cycle, bench holds pc.
REQ-010 commit_valid, commit_rd[3:0], commit_value[DATA_W-1:0]  outputs  registered; one retirement per cycle.
REQ-011 dbg_addr[3:0] input, dbg_data[DATA_W-1:0] output  combinational architectural register read.

Function
REQ-012 Instruction: op[15:12], rd[11:8], rs1[7:4], rs2[3:0]; op 0=NOP, 1=ADD, 2=SUB, 3=MUL, others treated as NOP.
REQ-013 regbank: 16 entries of {value, 4-bit tag}; tag 8 = no pending producer, tag 0-7 = producing ROB index.
REQ-014 ROB: 8 entries {busy, ready, rd, value}, head_p/tail_p 3-bit wrap-around, separate 4-bit occupancy count distinguishes full from empty.
REQ-015 Reservation stations: 2 add-class (ADD/SUB), 2 mul-class; each holds op, Vj/Vk, Qj/Qk, dest ROB index.
REQ-016 Issue at edge when issue_en && !stall: allocate ROB tail, allocate RS (non-NOP), read operands (value if tag 8, else ROB value if ready, else tag), set regbank[rd].tag = ROB index, tail_p+1.
REQ-017 NOP issues into ROB only, marked ready, commits without register write or commit_valid.
REQ-018 stall = issue_en && (ROB count==8 || no free RS of needed class).
REQ-019 Operand read in same cycle as CDB broadcast of that tag captures the broadcast value.
REQ-020 One add unit, one mul unit, each non-pipelined; dispatch the oldest (ROB order) RS with both operands ready, at earliest the edge after issue; RS freed on dispatch.
REQ-021 Result on CDB ADD_LAT/MUL_LAT edges after dispatch; CDB writes ROB value/ready and wakes waiting RS operands.
REQ-022 CDB conflict: mul wins; add unit holds its result and broadcasts next cycle, accepting no new dispatch meanwhile.
REQ-023 Commit: if ROB[head] ready, write value to regbank[rd], clear tag to 8 only if tag still equals head, free entry, head_p+1, pulse commit_valid with rd/value.
REQ-024 Issue and commit same rd same cycle: new issue tag wins.
REQ-025 Timing: independent ADD issued at edge E dispatches E+1, broadcasts E+1+ADD_LAT, commits E+2+ADD_LAT; MUL analogous.
REQ-026 Arithmetic modulo 2^DATA_W; MUL keeps low DATA_W bits; SUB = rs1-rs2.

Reset
REQ-027 On rst: regbank[k].value = k, all tags 8, ROB entries free, head_p=tail_p=0, count 0, RS and FUs idle, add/mul counters 0.
REQ-028 Outputs after reset: commit_valid 0, commit_rd 0, commit_value 0; stall 0 for issue_en low.
REQ-029 Reset mid-operation discards all in-flight instructions; instruction memory is not reset.

Configuration
REQ-030 With TOMASULO_STATS_EN defined: outputs commit_count[15:0] and stall_count[15:0] (saturating, cleared by rst) count commits (non-NOP) and stall cycles; without it those ports and counters are absent.

Verification
REQ-031 Reset, dbg_addr=5 -> dbg_data=5, commit_valid 0, stall 0.
REQ-032 imem[0]=ADD r1,r2,r3, issue at edge 0 -> commit_valid at edge 4, rd=1, value 5; dbg r1=5.
REQ-033 MUL r4,r2,r3 then ADD r5,r4,r1 -> commits r4=6 then r5=7 in order.
REQ-034 MUL r6,r3,r3 then ADD r7,r1,r1 -> ADD broadcasts first but commits after r6=9; r7=2.
REQ-035 MUL r8,r2,r2 then three ADDs dependent on r8 -> stall high on third ADD until an add RS frees; final values correct.
REQ-036 Assert rst during in-flight MUL -> no commit follows; r4 reads 4; new ADD issues normally.

Source files
------------

// File: rtl/tomasulo.sv
// Tomasulo out-of-order core: 16-entry regbank, 8-entry ROB, 2 add + 2 mul reservation stations.
// Define TOMASULO_STATS_EN to add saturating commit_count/stall_count outputs.
module tomasulo #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [3:0]        pc,
  input  logic              issue_en,
  input  logic              imem_we,
  input  logic [3:0]        imem_addr,
  input  logic [15:0]       imem_wdata,
  output logic              stall,
  output logic              commit_valid,
  output logic [3:0]        commit_rd,
  output logic [DATA_W-1:0] commit_value,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef TOMASULO_STATS_EN
  ,
  output logic [15:0]       commit_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int unsigned NREG  = 16;
  localparam int unsigned NROB  = 8;
  localparam int unsigned NRS   = 4;  // 0-1 add class, 2-3 mul class
  localparam int unsigned LAT_W = 8;
  localparam logic [3:0] TAG_NONE = 4'd8;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;

  logic [15:0]       imem_q [NREG];
  logic [DATA_W-1:0] rf_val_q [NREG], rf_val_d [NREG];
  logic [3:0]        rf_tag_q [NREG], rf_tag_d [NREG];
  logic              rob_busy_q [NROB], rob_busy_d [NROB];
  logic              rob_rdy_q [NROB], rob_rdy_d [NROB];
  logic              rob_nop_q [NROB], rob_nop_d [NROB];
  logic [3:0]        rob_rd_q [NROB], rob_rd_d [NROB];
  logic [DATA_W-1:0] rob_val_q [NROB], rob_val_d [NROB];
  logic [2:0]        head_q, head_d, tail_q, tail_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rs_busy_q [NRS], rs_busy_d [NRS];
  logic              rs_sub_q [NRS], rs_sub_d [NRS];
  logic [DATA_W-1:0] rs_vj_q [NRS], rs_vj_d [NRS], rs_vk_q [NRS], rs_vk_d [NRS];
  logic [3:0]        rs_qj_q [NRS], rs_qj_d [NRS], rs_qk_q [NRS], rs_qk_d [NRS];
  logic [2:0]        rs_dst_q [NRS], rs_dst_d [NRS];
  logic [LAT_W-1:0]  add_cnt_q, add_cnt_d, mul_cnt_q, mul_cnt_d;
  logic [2:0]        add_dst_q, add_dst_d, mul_dst_q, mul_dst_d;
  logic [DATA_W-1:0] add_res_q, add_res_d, mul_res_q, mul_res_d;
  logic              commit_valid_q, commit_valid_d;
  logic [3:0]        commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0] commit_value_q, commit_value_d;

  logic [15:0]       instr;
  logic [3:0]        op, rd;
  logic              is_add, is_mul, is_nop, do_issue;
  logic [1:0]        add_rs_sel, mul_rs_sel, rs_sel, add_pick, mul_pick;
  logic              mul_bc, add_bc, cdb_valid, add_unit_free, mul_unit_free, add_go, mul_go;
  logic [2:0]        cdb_tag;
  logic [DATA_W-1:0] cdb_val;
  logic [3:0]        src [2], stag [2], opq [2];
  logic [DATA_W-1:0] opv [2];
  logic              rs_rdy [NRS];
  logic [2:0]        rs_age [NRS];
  logic              commit_fire;

  assign instr    = imem_q[pc];
  assign op       = instr[15:12];
  assign rd       = instr[11:8];
  assign src[0]   = instr[7:4];
  assign src[1]   = instr[3:0];
  assign is_add   = (op == OP_ADD) || (op == OP_SUB);
  assign is_mul   = (op == OP_MUL);
  assign is_nop   = !is_add && !is_mul;
  assign add_rs_sel = !rs_busy_q[0] ? 2'd0 : 2'd1;
  assign mul_rs_sel = !rs_busy_q[2] ? 2'd2 : 2'd3;
  assign rs_sel     = is_mul ? mul_rs_sel : add_rs_sel;
  assign stall    = issue_en && ((cnt_q == 4'd8) ||
                                 (is_add && rs_busy_q[0] && rs_busy_q[1]) ||
                                 (is_mul && rs_busy_q[2] && rs_busy_q[3]));
  assign do_issue = issue_en && !stall;

  // Common data bus: mul always wins, add holds its result one more cycle
  assign mul_bc    = (mul_cnt_q == LAT_W'(1));
  assign add_bc    = (add_cnt_q == LAT_W'(1)) && !mul_bc;
  assign cdb_valid = mul_bc || add_bc;
  assign cdb_tag   = mul_bc ? mul_dst_q : add_dst_q;
  assign cdb_val   = mul_bc ? mul_res_q : add_res_q;

  // Operand fetch: regbank, else ready ROB entry, else same-cycle broadcast, else wait on tag
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      stag[s] = rf_tag_q[src[s]];
      opq[s]  = TAG_NONE;
      opv[s]  = rf_val_q[src[s]];
      if (!stag[s][3]) begin
        if (rob_rdy_q[stag[s][2:0]]) opv[s] = rob_val_q[stag[s][2:0]];
        else if (cdb_valid && (cdb_tag == stag[s][2:0])) opv[s] = cdb_val;
        else begin
          opq[s] = stag[s];
          opv[s] = '0;
        end
      end
    end
  end

  // Oldest-first selection among ready stations of each class
  always_comb begin
    for (int i = 0; i < NRS; i++) begin
      rs_rdy[i] = rs_busy_q[i] && (rs_qj_q[i] == TAG_NONE) && (rs_qk_q[i] == TAG_NONE);
      rs_age[i] = rs_dst_q[i] - head_q;
    end
    add_unit_free = (add_cnt_q == '0) || add_bc;
    mul_unit_free = (mul_cnt_q <= LAT_W'(1));
    add_go   = (rs_rdy[0] || rs_rdy[1]) && add_unit_free;
    mul_go   = (rs_rdy[2] || rs_rdy[3]) && mul_unit_free;
    add_pick = (rs_rdy[0] && (!rs_rdy[1] || (rs_age[0] < rs_age[1]))) ? 2'd0 : 2'd1;
    mul_pick = (rs_rdy[2] && (!rs_rdy[3] || (rs_age[2] < rs_age[3]))) ? 2'd2 : 2'd3;
  end

  always_comb begin
    rf_val_d = rf_val_q;     rf_tag_d = rf_tag_q;
    rob_busy_d = rob_busy_q; rob_rdy_d = rob_rdy_q; rob_nop_d = rob_nop_q;
    rob_rd_d = rob_rd_q;     rob_val_d = rob_val_q;
    head_d = head_q;         tail_d = tail_q;
    rs_busy_d = rs_busy_q;   rs_sub_d = rs_sub_q;
    rs_vj_d = rs_vj_q;       rs_vk_d = rs_vk_q;
    rs_qj_d = rs_qj_q;       rs_qk_d = rs_qk_q;  rs_dst_d = rs_dst_q;
    add_dst_d = add_dst_q;   add_res_d = add_res_q;
    mul_dst_d = mul_dst_q;   mul_res_d = mul_res_q;
    commit_valid_d = 1'b0;   commit_rd_d = commit_rd_q;  commit_value_d = commit_value_q;
    add_cnt_d = add_cnt_q;
    mul_cnt_d = mul_cnt_q;
    if (add_cnt_q > LAT_W'(1)) add_cnt_d = add_cnt_q - LAT_W'(1);
    else if (add_bc)           add_cnt_d = '0;
    if (mul_cnt_q != '0)       mul_cnt_d = mul_cnt_q - LAT_W'(1);

    if (cdb_valid) begin
      rob_rdy_d[cdb_tag] = 1'b1;
      rob_val_d[cdb_tag] = cdb_val;
      for (int i = 0; i < NRS; i++) begin
        if (rs_busy_q[i] && (rs_qj_q[i] == {1'b0, cdb_tag})) begin
          rs_vj_d[i] = cdb_val;
          rs_qj_d[i] = TAG_NONE;
        end
        if (rs_busy_q[i] && (rs_qk_q[i] == {1'b0, cdb_tag})) begin
          rs_vk_d[i] = cdb_val;
          rs_qk_d[i] = TAG_NONE;
        end
      end
    end

    if (add_go) begin
      rs_busy_d[add_pick] = 1'b0;
      add_cnt_d = LAT_W'(ADD_LAT);
      add_dst_d = rs_dst_q[add_pick];
      add_res_d = rs_sub_q[add_pick] ? (rs_vj_q[add_pick] - rs_vk_q[add_pick])
                                     : (rs_vj_q[add_pick] + rs_vk_q[add_pick]);
    end
    if (mul_go) begin
      rs_busy_d[mul_pick] = 1'b0;
      mul_cnt_d = LAT_W'(MUL_LAT);
      mul_dst_d = rs_dst_q[mul_pick];
      mul_res_d = rs_vj_q[mul_pick] * rs_vk_q[mul_pick];
    end

    // In-order retirement; a newer producer keeps ownership of the tag
    commit_fire = rob_busy_q[head_q] && rob_rdy_q[head_q];
    if (commit_fire) begin
      rob_busy_d[head_q] = 1'b0;
      rob_rdy_d[head_q]  = 1'b0;
      head_d = head_q + 3'd1;
      if (!rob_nop_q[head_q]) begin
        rf_val_d[rob_rd_q[head_q]] = rob_val_q[head_q];
        if (rf_tag_q[rob_rd_q[head_q]] == {1'b0, head_q}) rf_tag_d[rob_rd_q[head_q]] = TAG_NONE;
        commit_valid_d = 1'b1;
        commit_rd_d    = rob_rd_q[head_q];
        commit_value_d = rob_val_q[head_q];
      end
    end

    if (do_issue) begin
      rob_busy_d[tail_q] = 1'b1;
      rob_rdy_d[tail_q]  = is_nop;
      rob_nop_d[tail_q]  = is_nop;
      rob_rd_d[tail_q]   = rd;
      rob_val_d[tail_q]  = '0;
      tail_d = tail_q + 3'd1;
      if (!is_nop) begin
        rf_tag_d[rd]      = {1'b0, tail_q};
        rs_busy_d[rs_sel] = 1'b1;
        rs_sub_d[rs_sel]  = (op == OP_SUB);
        rs_vj_d[rs_sel]   = opv[0];
        rs_vk_d[rs_sel]   = opv[1];
        rs_qj_d[rs_sel]   = opq[0];
        rs_qk_d[rs_sel]   = opq[1];
        rs_dst_d[rs_sel]  = tail_q;
      end
    end
    cnt_d = cnt_q + {3'b0, do_issue} - {3'b0, commit_fire};
  end

  always_ff @(posedge clk1) begin
    if (imem_we) imem_q[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        rf_val_q[k] <= DATA_W'(k);
        rf_tag_q[k] <= TAG_NONE;
      end
      for (int k = 0; k < NROB; k++) begin
        rob_busy_q[k] <= 1'b0; rob_rdy_q[k] <= 1'b0; rob_nop_q[k] <= 1'b0;
        rob_rd_q[k]   <= '0;   rob_val_q[k] <= '0;
      end
      for (int k = 0; k < NRS; k++) begin
        rs_busy_q[k] <= 1'b0; rs_sub_q[k] <= 1'b0; rs_vj_q[k] <= '0; rs_vk_q[k] <= '0;
        rs_qj_q[k]   <= TAG_NONE; rs_qk_q[k] <= TAG_NONE; rs_dst_q[k] <= '0;
      end
      head_q <= '0; tail_q <= '0; cnt_q <= '0;
      add_cnt_q <= '0; add_dst_q <= '0; add_res_q <= '0;
      mul_cnt_q <= '0; mul_dst_q <= '0; mul_res_q <= '0;
      commit_valid_q <= 1'b0; commit_rd_q <= '0; commit_value_q <= '0;
    end else begin
      rf_val_q <= rf_val_d;     rf_tag_q <= rf_tag_d;
      rob_busy_q <= rob_busy_d; rob_rdy_q <= rob_rdy_d; rob_nop_q <= rob_nop_d;
      rob_rd_q <= rob_rd_d;     rob_val_q <= rob_val_d;
      rs_busy_q <= rs_busy_d;   rs_sub_q <= rs_sub_d;
      rs_vj_q <= rs_vj_d;       rs_vk_q <= rs_vk_d;
      rs_qj_q <= rs_qj_d;       rs_qk_q <= rs_qk_d;  rs_dst_q <= rs_dst_d;
      head_q <= head_d; tail_q <= tail_d; cnt_q <= cnt_d;
      add_cnt_q <= add_cnt_d; add_dst_q <= add_dst_d; add_res_q <= add_res_d;
      mul_cnt_q <= mul_cnt_d; mul_dst_q <= mul_dst_d; mul_res_q <= mul_res_d;
      commit_valid_q <= commit_valid_d; commit_rd_q <= commit_rd_d; commit_value_q <= commit_value_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign dbg_data     = rf_val_q[dbg_addr];

`ifdef TOMASULO_STATS_EN
  logic [15:0] commit_count_q, stall_count_q;

  always_ff @(posedge clk1) begin
    if (rst) begin
      commit_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      if (commit_valid_d && (commit_count_q != 16'hFFFF)) commit_count_q <= commit_count_q + 16'd1;
      if (stall && (stall_count_q != 16'hFFFF))           stall_count_q  <= stall_count_q + 16'd1;
    end
  end

  assign commit_count = commit_count_q;
  assign stall_count  = stall_count_q;
`endif

endmodule

// File: tb/tb_tomasulo.sv
// Testbench for tomasulo: directed scenarios plus random programs against an in-order ISA model.
module tb_tomasulo;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADD_LAT = 2;
  localparam int unsigned MUL_LAT = 4;

  logic              clk1 = 1'b0;
  logic              rst, issue_en, imem_we;
  logic [3:0]        pc, imem_addr, dbg_addr;
  logic [15:0]       imem_wdata;
  logic              stall, commit_valid;
  logic [3:0]        commit_rd;
  logic [DATA_W-1:0] commit_value, dbg_data;
`ifdef TOMASULO_STATS_EN
  logic [15:0]       commit_count, stall_count;
`endif

  tomasulo #(.DATA_W(DATA_W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk1(clk1), .rst(rst), .pc(pc), .issue_en(issue_en),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .stall(stall), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef TOMASULO_STATS_EN
    , .commit_count(commit_count), .stall_count(stall_count)
`endif
  );

  always #5 clk1 = ~clk1;

  typedef struct packed { logic [3:0] rd; logic [DATA_W-1:0] v; } exp_t;

  int                n_vec = 0;
  int                n_bad = 0;
  int                n_commits = 0;
  bit                stalled;
  logic [DATA_W-1:0] m_rf [16];
  logic [15:0]       m_imem [16];
  exp_t              exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int a, input int b);
    return {4'(op), 4'(rd), 4'(a), 4'(b)};
  endfunction

  // Sequential ISA semantics: each accepted issue executes immediately in program order
  function automatic void model_exec(input logic [15:0] w);
    logic [DATA_W-1:0] a, b, r;
    exp_t e;
    a = m_rf[w[7:4]];
    b = m_rf[w[3:0]];
    case (w[15:12])
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd3: r = a * b;
      default: return;
    endcase
    m_rf[w[11:8]] = r;
    e.rd = w[11:8];
    e.v  = r;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk1) begin : mon
    exp_t e;
    if (!rst && commit_valid) begin
      n_commits++;
      if (exp_q.size() == 0) check("spurious_commit", 32'(commit_rd), 32'hFF);
      else begin
        e = exp_q.pop_front();
        check("commit_rd", 32'(commit_rd), 32'(e.rd));
        check("commit_value", 32'(commit_value), 32'(e.v));
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_en = 1'b0;
    imem_we = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) m_rf[k] = DATA_W'(k);
  endtask

  task automatic load(input int a, input logic [15:0] w);
    imem_we = 1'b1;
    imem_addr = 4'(a);
    imem_wdata = w;
    tick();
    imem_we = 1'b0;
    m_imem[a] = w;
  endtask

  task automatic issue(input int a);
    bit ok;
    ok = 1'b0;
    stalled = 1'b0;
    pc = 4'(a);
    issue_en = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk1);
      if (stall) stalled = 1'b1;
      else ok = 1'b1;
      tick();
    end
    issue_en = 1'b0;
    if (ok) model_exec(m_imem[a]);
    else check("issue_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_commit(output int lat);
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick();
      if (commit_valid) lat = k;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (12) tick();
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [DATA_W-1:0] e);
    dbg_addr = 4'(r);
    #1;
    check(tag, 32'(dbg_data), 32'(e));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, snap;
    bit any;
    rst = 1'b1; issue_en = 1'b0; imem_we = 1'b0; pc = '0;
    imem_addr = '0; imem_wdata = '0; dbg_addr = '0;
    do_reset();

    dbg_addr = 4'd5;
    #1;
    check("rst_dbg5", 32'(dbg_data), 32'd5);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_commit_rd", 32'(commit_rd), 32'd0);
    check("rst_commit_value", 32'(commit_value), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    load(0,  enc(1, 1, 2, 3));
    load(1,  enc(3, 4, 2, 3));
    load(2,  enc(1, 5, 4, 1));
    load(3,  enc(3, 6, 3, 3));
    load(4,  enc(1, 7, 1, 1));
    load(5,  enc(3, 8, 2, 2));
    load(6,  enc(1, 9, 8, 1));
    load(7,  enc(1, 10, 8, 1));
    load(8,  enc(1, 11, 8, 8));
    load(9,  enc(0, 0, 0, 0));
    load(10, enc(2, 14, 2, 3));
    load(11, enc(3, 12, 2, 3));
    load(12, enc(3, 13, 12, 12));

    // single ADD latency and result
    issue(0);
    wait_commit(lat);
    check("add_latency", 32'(lat), 32'(ADD_LAT + 2));
    drain();
    chk_reg("add_r1", 1, 8'd5);

    // MUL followed by dependent ADD
    do_reset();
    issue(1);
    issue(2);
    drain();
    chk_reg("dep_r4", 4, 8'd6);
    chk_reg("dep_r5", 5, 8'd7);

    // MUL latency, then SUB wrapping below zero
    do_reset();
    issue(1);
    wait_commit(lat);
    check("mul_latency", 32'(lat), 32'(MUL_LAT + 2));
    issue(10);
    drain();
    chk_reg("sub_wrap_r14", 14, 8'hFF);

    // younger ADD finishes first but retires after the MUL
    do_reset();
    issue(3);
    issue(4);
    drain();
    chk_reg("ooo_r6", 6, 8'd9);
    chk_reg("ooo_r7", 7, 8'd2);

    // add reservation stations exhausted
    do_reset();
    issue(5);
    issue(6);
    check("add1_no_stall", 32'(stalled), 32'd0);
    issue(7);
    check("add2_no_stall", 32'(stalled), 32'd0);
    issue(8);
    check("add3_stalled", 32'(stalled), 32'd1);
    drain();
    chk_reg("rs_r8", 8, 8'd4);
    chk_reg("rs_r9", 9, 8'd5);
    chk_reg("rs_r10", 10, 8'd5);
    chk_reg("rs_r11", 11, 8'd8);

    // ROB fills behind a chained MUL pair
    do_reset();
    issue(11);
    issue(12);
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue(9);
      any |= stalled;
    end
    check("rob_full_stall", 32'(any), 32'd1);
    drain();
    chk_reg("rob_r12", 12, 8'd6);
    chk_reg("rob_r13", 13, 8'd36);

    // reset while a MUL is in flight
    do_reset();
    issue(1);
    repeat (2) tick();
    snap = n_commits;
    do_reset();
    repeat (10) tick();
    check("no_commit_after_rst", 32'(n_commits - snap), 32'd0);
    chk_reg("rst_r4", 4, 8'd4);
    issue(0);
    check("post_rst_no_stall", 32'(stalled), 32'd0);
    drain();
    chk_reg("post_rst_r1", 1, 8'd5);

    // random programs
    do_reset();
    for (int a = 0; a < 16; a++)
      load(a, enc(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0)
        load(int'($urandom_range(0, 15)),
             enc(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
      issue(int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    for (int r = 0; r < 16; r++) chk_reg("rand_reg", r, m_rf[r]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
